// File: rtl/hazard_scoreboard_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_scoreboard_ctrl : per-register latency scoreboard driving pipeline
// load/flush controls, with saturating stall/flush counters.   Rev 1.0
// ============================================================================
module hazard_scoreboard_ctrl #(
   parameter int NUM_SRC    = 2,
   parameter int NUM_STAGES = 5,
   parameter int MAX_LAT    = 3,
   parameter int CNT_W      = 32,
   localparam int LAT_W     = $clog2(MAX_LAT + 1)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    id_valid_i,
   input  logic [NUM_SRC*5-1:0]    id_rs_addr_i,
   input  logic [NUM_SRC-1:0]      id_rs_used_i,
   input  logic [4:0]              id_rd_addr_i,
   input  logic [LAT_W-1:0]        id_wr_lat_i,
   input  logic                    redirect_i,
   input  logic                    imem_rdy_i,
   input  logic                    dmem_busy_i,
   input  logic                    perf_clr_i,
   output logic [NUM_STAGES-1:0]   ld_o,
   output logic [NUM_STAGES-1:0]   flush_o,
   output logic                    hzd_stall_o,
   output logic [CNT_W-1:0]        stall_data_cnt_o,
   output logic [CNT_W-1:0]        stall_mem_cnt_o,
   output logic [CNT_W-1:0]        flush_cnt_o
);

   // Entry 0 exists only to keep indexing simple; it is never written nonzero.
   logic [LAT_W-1:0]      sb_q [0:31];
   logic [LAT_W-1:0]      sb_d [0:31];
   logic [LAT_W-1:0]      lat_clamped;
   logic                  data_hzd;
   logic                  case_mem, case_redir, case_hzd, case_imem;
   logic [NUM_STAGES-1:0] ld_c, flush_c;
   logic                  issue;
   logic [CNT_W-1:0]      stall_data_cnt_q, stall_mem_cnt_q, flush_cnt_q;

   always_comb begin
      data_hzd = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (id_rs_used_i[k] && (id_rs_addr_i[5*k +: 5] != 5'd0) &&
             (sb_q[id_rs_addr_i[5*k +: 5]] != '0))
            data_hzd = 1'b1;
      end
      data_hzd = data_hzd & id_valid_i;
   end

   always_comb begin
      ld_c       = '1;
      flush_c    = '0;
      case_mem   = 1'b0;
      case_redir = 1'b0;
      case_hzd   = 1'b0;
      case_imem  = 1'b0;
      if (dmem_busy_i) begin
         ld_c     = '0;
         case_mem = 1'b1;
      end else if (redirect_i) begin
         flush_c[1] = 1'b1;
         flush_c[2] = 1'b1;
         case_redir = 1'b1;
      end else if (data_hzd) begin
         ld_c[0]    = 1'b0;
         ld_c[1]    = 1'b0;
         flush_c[2] = 1'b1;
         case_hzd   = 1'b1;
      end else if (!imem_rdy_i) begin
         ld_c[0]    = 1'b0;
         flush_c[1] = 1'b1;
         case_imem  = 1'b1;
      end
   end

   // Reset forces the controls low immediately, not just at the next edge.
   assign ld_o        = rst_i ? '0 : ld_c;
   assign flush_o     = rst_i ? '0 : flush_c;
   assign hzd_stall_o = ~rst_i & case_hzd;

   assign issue       = id_valid_i & ld_c[2] & ~flush_c[2] & (id_rd_addr_i != 5'd0);
   assign lat_clamped = (int'(id_wr_lat_i) > MAX_LAT) ? LAT_W'(MAX_LAT) : id_wr_lat_i;

   always_comb begin
      for (int i = 0; i < 32; i++) sb_d[i] = sb_q[i];
      if (!case_mem) begin
         for (int i = 1; i < 32; i++)
            if (sb_q[i] != '0) sb_d[i] = sb_q[i] - LAT_W'(1);
      end
      if (issue) sb_d[id_rd_addr_i] = lat_clamped;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < 32; i++) sb_q[i] <= '0;
      end else begin
         for (int i = 0; i < 32; i++) sb_q[i] <= sb_d[i];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_data_cnt_q <= '0;
         stall_mem_cnt_q  <= '0;
         flush_cnt_q      <= '0;
      end else if (perf_clr_i) begin
         stall_data_cnt_q <= '0;
         stall_mem_cnt_q  <= '0;
         flush_cnt_q      <= '0;
      end else begin
         if (case_hzd && (stall_data_cnt_q != '1))
            stall_data_cnt_q <= stall_data_cnt_q + CNT_W'(1);
         if ((case_mem || case_imem) && (stall_mem_cnt_q != '1))
            stall_mem_cnt_q <= stall_mem_cnt_q + CNT_W'(1);
         if (case_redir && (flush_cnt_q != '1))
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign stall_data_cnt_o = stall_data_cnt_q;
   assign stall_mem_cnt_o  = stall_mem_cnt_q;
   assign flush_cnt_o      = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_hazard_scoreboard_ctrl : directed self-checking bench.   Rev 1.0
// ============================================================================
module tb_hazard_scoreboard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [9:0]  id_rs_addr;
   logic [1:0]  id_rs_used;
   logic [4:0]  id_rd_addr;
   logic [1:0]  id_wr_lat;
   logic        redirect, imem_rdy, dmem_busy, perf_clr;
   logic [4:0]  ld, flush, ld_s, flush_s;
   logic        hzd, hzd_s;
   logic [31:0] sd_cnt, sm_cnt, fl_cnt;
   logic [3:0]  sd_cnt_s, sm_cnt_s, fl_cnt_s;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hazard_scoreboard_ctrl #(.NUM_SRC(2), .NUM_STAGES(5), .MAX_LAT(3), .CNT_W(32)) u_dut (
      .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_addr_i(id_rs_addr),
      .id_rs_used_i(id_rs_used), .id_rd_addr_i(id_rd_addr), .id_wr_lat_i(id_wr_lat),
      .redirect_i(redirect), .imem_rdy_i(imem_rdy), .dmem_busy_i(dmem_busy),
      .perf_clr_i(perf_clr), .ld_o(ld), .flush_o(flush), .hzd_stall_o(hzd),
      .stall_data_cnt_o(sd_cnt), .stall_mem_cnt_o(sm_cnt), .flush_cnt_o(fl_cnt));

   hazard_scoreboard_ctrl #(.NUM_SRC(2), .NUM_STAGES(5), .MAX_LAT(3), .CNT_W(4)) u_sat (
      .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_addr_i(id_rs_addr),
      .id_rs_used_i(id_rs_used), .id_rd_addr_i(id_rd_addr), .id_wr_lat_i(id_wr_lat),
      .redirect_i(redirect), .imem_rdy_i(imem_rdy), .dmem_busy_i(dmem_busy),
      .perf_clr_i(perf_clr), .ld_o(ld_s), .flush_o(flush_s), .hzd_stall_o(hzd_s),
      .stall_data_cnt_o(sd_cnt_s), .stall_mem_cnt_o(sm_cnt_s), .flush_cnt_o(fl_cnt_s));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_valid = 1'b0; id_rs_addr = '0; id_rs_used = '0; id_rd_addr = '0; id_wr_lat = '0;
      redirect = 1'b0; imem_rdy = 1'b1; dmem_busy = 1'b0; perf_clr = 1'b0;
   endtask

   task automatic instr(input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used,
                        input logic [4:0] rd, input logic [1:0] lat);
      id_valid = 1'b1; id_rs_addr = {rs1, rs0}; id_rs_used = used;
      id_rd_addr = rd; id_wr_lat = lat;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      #3;
      check("rst_ld", 32'(ld), 32'h0);
      check("rst_flush", 32'(flush), 32'h0);
      check("rst_hzd", 32'(hzd), 32'h0);
      check("rst_cnt", sd_cnt | sm_cnt | fl_cnt, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Load-use: lw x5 then add x6,x5,x1
      cyc(); instr(5'd2, 5'd0, 2'b01, 5'd5, 2'd1);
      @(negedge clk);
      check("lu_issue_ld", 32'(ld), 32'h1f);
      cyc(); instr(5'd5, 5'd1, 2'b11, 5'd6, 2'd0);
      @(negedge clk);
      check("lu_hzd", 32'(hzd), 32'h1);
      check("lu_ld", 32'(ld), 32'h1c);
      check("lu_flush", 32'(flush), 32'h04);
      cyc();
      @(negedge clk);
      check("lu_clean_hzd", 32'(hzd), 32'h0);
      check("lu_clean_ld", 32'(ld), 32'h1f);
      check("lu_cnt", sd_cnt, 32'd1);

      // Latency 3 producer x7, dependent consumer
      cyc(); instr(5'd1, 5'd0, 2'b01, 5'd7, 2'd3);
      cyc(); instr(5'd7, 5'd0, 2'b01, 5'd8, 2'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("l3_hzd_%0d", i), 32'(hzd), (i < 3) ? 32'h1 : 32'h0);
         cyc();
      end
      check("l3_cnt", sd_cnt, 32'd4);

      // Latency 3 with a 2-cycle dmem freeze in the middle of the stall
      instr(5'd1, 5'd0, 2'b01, 5'd7, 2'd3);
      cyc(); instr(5'd7, 5'd0, 2'b01, 5'd8, 2'd0);
      @(negedge clk);
      check("fz_hzd0", 32'(hzd), 32'h1);
      cyc(); dmem_busy = 1'b1;
      @(negedge clk);
      check("fz_ld", 32'(ld), 32'h0);
      check("fz_hzd_masked", 32'(hzd), 32'h0);
      check("fz_flush", 32'(flush), 32'h0);
      cyc();
      @(negedge clk);
      check("fz_ld2", 32'(ld), 32'h0);
      cyc(); dmem_busy = 1'b0;
      @(negedge clk);
      check("fz_hzd1", 32'(hzd), 32'h1);
      cyc();
      @(negedge clk);
      check("fz_hzd2", 32'(hzd), 32'h1);
      cyc();
      @(negedge clk);
      check("fz_done", 32'(hzd), 32'h0);
      check("fz_data_cnt", sd_cnt, 32'd7);
      check("fz_mem_cnt", sm_cnt, 32'd2);

      // x0 destination and unused sources never hazard
      cyc(); instr(5'd1, 5'd0, 2'b00, 5'd0, 2'd2);
      cyc(); instr(5'd0, 5'd0, 2'b01, 5'd11, 2'd0);
      @(negedge clk);
      check("x0_hzd", 32'(hzd), 32'h0);
      check("x0_ld", 32'(ld), 32'h1f);
      cyc(); instr(5'd1, 5'd0, 2'b01, 5'd10, 2'd3);
      cyc(); instr(5'd10, 5'd10, 2'b00, 5'd12, 2'd0);
      @(negedge clk);
      check("unused_hzd", 32'(hzd), 32'h0);
      cyc(); idle();
      cyc(); cyc(); cyc();

      // Redirect wins over a simultaneous data hazard
      instr(5'd1, 5'd0, 2'b01, 5'd9, 2'd2);
      cyc(); instr(5'd9, 5'd0, 2'b01, 5'd13, 2'd0); redirect = 1'b1;
      @(negedge clk);
      check("rd_flush", 32'(flush), 32'h06);
      check("rd_ld", 32'(ld), 32'h1f);
      check("rd_hzd", 32'(hzd), 32'h0);
      cyc(); idle();
      @(negedge clk);
      check("rd_flush_cnt", fl_cnt, 32'd1);
      check("rd_data_cnt", sd_cnt, 32'd7);
      cyc(); cyc();

      // imem wait saturation on the 4-bit counter instance
      perf_clr = 1'b1;
      cyc(); perf_clr = 1'b0;
      @(negedge clk);
      check("clr_mem_cnt", sm_cnt, 32'd0);
      cyc(); imem_rdy = 1'b0;
      @(negedge clk);
      check("im_ld", 32'(ld), 32'h1e);
      check("im_flush", 32'(flush), 32'h02);
      for (int i = 0; i < 19; i++) cyc();
      cyc(); imem_rdy = 1'b1;
      @(negedge clk);
      check("sat_cnt", 32'(sm_cnt_s), 32'd15);
      check("wide_cnt", sm_cnt, 32'd20);
      cyc(); perf_clr = 1'b1;
      cyc(); perf_clr = 1'b0;
      @(negedge clk);
      check("sat_clr", 32'(sm_cnt_s), 32'd0);
      check("wide_clr", sm_cnt, 32'd0);

      // Asynchronous reset in the middle of a stall
      cyc(); instr(5'd1, 5'd0, 2'b01, 5'd5, 2'd3);
      cyc(); instr(5'd5, 5'd0, 2'b01, 5'd14, 2'd0);
      @(negedge clk);
      check("ar_pre_hzd", 32'(hzd), 32'h1);
      #1 rst = 1'b1;
      #1;
      check("ar_ld", 32'(ld), 32'h0);
      check("ar_flush", 32'(flush), 32'h0);
      check("ar_hzd", 32'(hzd), 32'h0);
      check("ar_data_cnt", sd_cnt, 32'd0);
      check("ar_flush_cnt", fl_cnt, 32'd0);
      cyc(); rst = 1'b0;
      @(negedge clk);
      check("ar_post_hzd", 32'(hzd), 32'h0);
      check("ar_post_ld", 32'(ld), 32'h1f);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
